// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - Op-code constants (OP_ADD .. OP_DIVU; 12-15 are unsupported and return zero).
//   - FSM state encoding for the top-level controller.
//   - ceil_log2 helper, used for the shift-amount width and the iteration counter width.
// Optional feature macro: SEQ_ALU_DIV_EN (see seq_alu.sv).

package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative datapath for unsigned multiply (shift-add) and, when
// SEQ_ALU_DIV_EN is defined, unsigned restoring divide. One bit per step.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_start         load operands and clear the accumulator (i_a, i_b, i_mode sampled)
//   i_mode          0 = multiply, 1 = divide (ignored when the divider is not built)
//   i_step          perform one iteration
//   i_a, i_b        multiplicand/multiplier or dividend/divisor
//   o_hi_nxt        high word after the current step (product high / remainder)
//   o_lo_nxt        low word after the current step (product low / quotient)
//
// The outputs show the value the registers take on the next step, so the controller
// can capture the final result on the same edge as the last iteration.

module seq_alu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);

    logic [WIDTH-1:0] r_hi;  // product high accumulator / partial remainder
    logic [WIDTH-1:0] r_lo;  // multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] r_b;   // multiplicand / divisor

    // Shift-add: add the multiplicand when the current multiplier LSB is set, then shift
    // the whole {hi, lo} pair right by one, carry included.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic             r_mode;
    // Restoring divide: bring the next dividend bit into the partial remainder and
    // subtract the divisor; a borrow (bit WIDTH set) means restore and quotient bit 0.
    // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_qbit   = ~w_diff[WIDTH];
    assign w_div_hi = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_qbit};

    assign o_hi_nxt = r_mode ? w_div_hi : w_mul_hi;
    assign o_lo_nxt = r_mode ? w_div_lo : w_mul_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 1'b0;
        end else if (i_start) begin
            r_mode <= i_mode;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode;

    assign o_hi_nxt = w_mul_hi;
    assign o_lo_nxt = w_mul_lo;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_start) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            r_hi <= o_hi_nxt;
            r_lo <= o_lo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Basic ops complete in one registered cycle; MULU (and DIVU when enabled) iterate
// over WIDTH cycles in seq_alu_iter.
//
// Optional feature macro: SEQ_ALU_DIV_EN. When undefined, no divide state or datapath
// is built and op 11 returns zero in a single cycle like the other unsupported codes.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_in_valid       operation presented
//   o_in_ready       can accept (IDLE only)
//   i_op             op code (seq_alu_pkg::OP_*)
//   i_a, i_b         operands, sampled on accept
//   o_out_valid      result available (DONE), held until consumed
//   i_out_ready      consumer takes result
//   o_result         low word / quotient
//   o_result_hi      high word / remainder; 0 for basic ops
//   o_busy           MUL or DIV in progress

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_busy
);

    localparam int unsigned SHW   = ceil_log2(WIDTH);
    localparam int unsigned CNT_W = ceil_log2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_d;
    logic [WIDTH-1:0] r_result_hi;
    logic [WIDTH-1:0] w_result_hi_d;

    logic [WIDTH-1:0] w_basic;
    logic [SHW-1:0]   w_shamt;
    logic             w_iter_start;
    logic             w_iter_mode;
    logic             w_iter_step;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;

    assign w_shamt = i_b[SHW-1:0];

    // Single-cycle ops evaluated on the live inputs; only captured on accept.
    always_comb begin
        w_basic = '0;
        case (i_op)
            OP_ADD:  w_basic = i_a + i_b;
            OP_SUB:  w_basic = i_a - i_b;
            OP_AND:  w_basic = i_a & i_b;
            OP_OR:   w_basic = i_a | i_b;
            OP_SRL:  w_basic = i_a >> w_shamt;
            OP_SRA:  w_basic = $unsigned($signed(i_a) >>> w_shamt);
            OP_SLL:  w_basic = i_a << w_shamt;
            OP_XOR:  w_basic = i_a ^ i_b;
            OP_SLT:  w_basic = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU: w_basic = {{(WIDTH-1){1'b0}}, i_a < i_b};
            default: w_basic = '0;
        endcase
    end

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_iter_start),
        .i_mode   (w_iter_mode),
        .i_step   (w_iter_step),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_hi_nxt (w_iter_hi),
        .o_lo_nxt (w_iter_lo)
    );

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_result_d    = r_result;
        w_result_hi_d = r_result_hi;
        w_iter_start  = 1'b0;
        w_iter_mode   = 1'b0;
        w_iter_step   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    if (i_op == OP_MULU) begin
                        w_iter_start = 1'b1;
                        w_cnt_d      = '0;
                        w_state_d    = StMul;
`ifdef SEQ_ALU_DIV_EN
                    end else if (i_op == OP_DIVU) begin
                        w_iter_start = 1'b1;
                        w_iter_mode  = 1'b1;
                        w_cnt_d      = '0;
                        w_state_d    = StDiv;
`endif
                    end else begin
                        w_result_d    = w_basic;
                        w_result_hi_d = '0;
                        w_state_d     = StDone;
                    end
                end
            end
`ifdef SEQ_ALU_DIV_EN
            StMul, StDiv: begin
`else
            StMul: begin
`endif
                w_iter_step = 1'b1;
                w_cnt_d     = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_result_d    = w_iter_lo;
                    w_result_hi_d = w_iter_hi;
                    w_state_d     = StDone;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_result    <= w_result_d;
            r_result_hi <= w_result_hi_d;
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_busy      = (r_state == StMul) || (r_state == StDiv);
    assign o_out_valid = (r_state == StDone);
    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=32).
// Directed vector table, hand-written backpressure and mid-operation reset sequences,
// then random operations checked against a plain-arithmetic reference model.
// Honours SEQ_ALU_DIV_EN for the expected behaviour of op 11.

module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int unsigned W = 32;
`ifdef SEQ_ALU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [3:0]   i_op = '0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [W-1:0] o_result;
    logic [W-1:0] o_result_hi;
    logic         o_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_result_hi (o_result_hi),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] lo, input logic [W-1:0] hi, input int lat,
                                input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.lat = lat; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: results from the op definitions using wide arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi, output int lat);
        logic [63:0]         p;
        logic signed [W-1:0] sa;
        int                  sh;
        sa  = a;
        sh  = int'(b % W);
        lo  = '0;
        hi  = '0;
        lat = 1;
        case (op)
            4'd0: lo = a + b;
            4'd1: lo = a - b;
            4'd2: lo = a & b;
            4'd3: lo = a | b;
            4'd4: lo = a >> sh;
            4'd5: lo = sa >>> sh;
            4'd6: lo = a << sh;
            4'd7: lo = a ^ b;
            4'd8: lo = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: lo = (a < b) ? 1 : 0;
            4'd10: begin
                p   = 64'(a) * 64'(b);
                lo  = p[31:0];
                hi  = p[63:32];
                lat = W + 1;
            end
            4'd11: begin
                if (DivEn) begin
                    lat = W + 1;
                    if (b == 0) begin
                        lo = '1;
                        hi = a;
                    end else begin
                        lo = a / b;
                        hi = a % b;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one op, wait for the result (bounded), check latency/busy/result, consume it.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input int exp_lat, input string name);
        int w;
        int lat;
        int busy_n;
        w = 0;
        while (!o_in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, " in_ready"}, 64'(o_in_ready), 64'(1));
        i_in_valid = 1'b1;
        i_op = op;
        i_a = a;
        i_b = b;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_op = 4'($urandom);
        i_a = $urandom;
        i_b = $urandom;
        lat = 1;
        busy_n = 0;
        while (!o_out_valid && lat < 100) begin
            if (o_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        chk({name, " result"}, 64'(o_result), 64'(exp_lo));
        chk({name, " result_hi"}, 64'(o_result_hi), 64'(exp_hi));
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        chk({name, " out_valid_after_take"}, 64'(o_out_valid), 64'(0));
    endtask

    initial begin
        logic [W-1:0] e_lo;
        logic [W-1:0] e_hi;
        int           e_lat;
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           seen_valid;

        vecs.push_back(mk(OP_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1, "add_wrap"));
        vecs.push_back(mk(OP_SUB,  32'h5, 32'h7, 32'hFFFF_FFFE, 32'h0, 1, "sub_wrap"));
        vecs.push_back(mk(OP_AND,  32'hF0F0_F0F0, 32'h1234_5678, 32'h1030_5070, 32'h0, 1, "and"));
        vecs.push_back(mk(OP_OR,   32'h0F0F_0000, 32'h00F0_F00F, 32'h0FFF_F00F, 32'h0, 1, "or"));
        vecs.push_back(mk(OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'h0, 1, "xor"));
        vecs.push_back(mk(OP_SRL,  32'h8000_0000, 32'd31, 32'h1, 32'h0, 1, "srl31"));
        vecs.push_back(mk(OP_SRA,  32'h8000_0000, 32'd36, 32'hF800_0000, 32'h0, 1, "sra_b36"));
        vecs.push_back(mk(OP_SLL,  32'h1, 32'h21, 32'h2, 32'h0, 1, "sll_b33"));
        vecs.push_back(mk(OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1, "slt"));
        vecs.push_back(mk(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1, "sltu"));
        vecs.push_back(mk(OP_MULU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h1, 33, "mulu_max2"));
        vecs.push_back(mk(OP_MULU, 32'd12345, 32'd678, 32'h007F_B6F6, 32'h0, 33, "mulu_small"));
        if (DivEn) begin
            vecs.push_back(mk(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7"));
            vecs.push_back(mk(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 33, "divu_by0"));
        end else begin
            vecs.push_back(mk(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1, "divu_off"));
            vecs.push_back(mk(OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0, 1, "divu_off_by0"));
        end
        vecs.push_back(mk(4'd12, 32'hDEAD_BEEF, 32'h1234, 32'h0, 32'h0, 1, "op12"));
        vecs.push_back(mk(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, "op15"));

        // Reset, then idle state.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset out_valid", 64'(o_out_valid), 64'(0));
        chk("reset busy", 64'(o_busy), 64'(0));
        chk("reset in_ready", 64'(o_in_ready), 64'(1));
        chk("reset result", 64'(o_result), 64'(0));
        chk("reset result_hi", 64'(o_result_hi), 64'(0));

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].lat,
                   vecs[i].name);
        end

        // Backpressure: DONE held with frozen outputs, in_valid pulses ignored.
        i_in_valid = 1'b1; i_op = OP_ADD; i_a = 32'd7; i_b = 32'd8;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_in_valid = k[0];
            i_op = OP_SUB;
            i_a = $urandom;
            i_b = $urandom;
            chk("bp out_valid", 64'(o_out_valid), 64'(1));
            chk("bp in_ready", 64'(o_in_ready), 64'(0));
            chk("bp result", 64'(o_result), 64'(15));
            @(posedge clk); #1;
        end
        // Handoff with in_valid still high: must not be accepted in the same cycle.
        i_in_valid = 1'b1;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_out_ready = 1'b0;
        chk("handoff in_ready", 64'(o_in_ready), 64'(1));
        chk("handoff out_valid", 64'(o_out_valid), 64'(0));
        chk("idle keeps result", 64'(o_result), 64'(15));

        // Reset at C+10 of a MULU aborts it.
        i_in_valid = 1'b1; i_op = OP_MULU; i_a = 32'hFFFF_FFFF; i_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid busy", 64'(o_busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort in_ready", 64'(o_in_ready), 64'(1));
        chk("abort busy", 64'(o_busy), 64'(0));
        chk("abort result", 64'(o_result), 64'(0));
        chk("abort result_hi", 64'(o_result_hi), 64'(0));
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort no out_valid", 64'(seen_valid), 64'(0));
        run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1, "add_after_reset");

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: ra = '1;
                2: rb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            model(rop, ra, rb, e_lo, e_hi, e_lat);
            run_op(rop, ra, rb, e_lo, e_hi, e_lat, $sformatf("rand%0d_op%0d", n, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
